// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_UP     = 4'h2;
  localparam logic [3:0] KEY_LEFT   = 4'h4;
  localparam logic [3:0] KEY_RIGHT  = 4'h6;
  localparam logic [3:0] KEY_DOWN   = 4'h8;
  localparam logic [3:0] KEY_STAR   = 4'hE;
  localparam logic [3:0] KEY_HASH   = 4'hF;

  localparam logic [3:0] COLS_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE  = 4'b1111;

  // Lowest-indexed active-low row; multiple presses resolve to the lowest row.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index of the single driven (low) column.
  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Maps a (column, row) position on the keypad to its 4-bit key code.
module keypad_decoder
  import keypad_pkg::*;
(
  input  logic [1:0] col_i,
  input  logic [1:0] row_i,
  output logic [3:0] code_c_o
);

  // Row-major key map: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  always_comb begin
    code_c_o = 4'h0;
    case ({row_i, col_i})
      4'b0000: code_c_o = 4'h1;
      4'b0001: code_c_o = KEY_UP;
      4'b0010: code_c_o = 4'h3;
      4'b0011: code_c_o = 4'hA;
      4'b0100: code_c_o = KEY_LEFT;
      4'b0101: code_c_o = 4'h5;
      4'b0110: code_c_o = KEY_RIGHT;
      4'b0111: code_c_o = 4'hB;
      4'b1000: code_c_o = 4'h7;
      4'b1001: code_c_o = KEY_DOWN;
      4'b1010: code_c_o = 4'h9;
      4'b1011: code_c_o = 4'hC;
      4'b1100: code_c_o = KEY_STAR;
      4'b1101: code_c_o = 4'h0;
      4'b1110: code_c_o = KEY_HASH;
      default: code_c_o = 4'hD;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning, debouncing 4x4 keypad front end: one code + one strobe per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic [3:0] rows_i,
  output logic [3:0] cols_o,
  output logic [3:0] key_o,
  output logic       enable_move_o,
  output logic       key_held_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

  logic [3:0]       sync1_q, rs_q;
  logic [DIV_W-1:0] div_q;
  state_e           state_q, state_d;
  logic [3:0]       cols_q, cols_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [3:0]       key_q, key_d;
  logic             strobe_q, strobe_d;
  logic             held_q, held_d;

  logic             tick_c;
  logic             idle_c;
  logic             same_row_c;
  logic [1:0]       cur_row_c;
  logic [3:0]       cols_adv_c;
  logic [DEB_W-1:0] deb_inc_c;
  logic [3:0]       code_c;

  assign tick_c     = (div_q == DIV_LAST);
  assign idle_c     = (rs_q == ROWS_IDLE);
  assign cur_row_c  = low_row(rs_q);
  assign same_row_c = !idle_c && (cur_row_c == cand_row_q);
  assign cols_adv_c = {cols_q[2:0], cols_q[3]};
  assign deb_inc_c  = deb_q + DEB_W'(1);

  keypad_decoder u_decoder (
    .col_i    (cand_col_q),
    .row_i    (cand_row_q),
    .code_c_o (code_c)
  );

  // Two-flop synchronizer for the asynchronous, idle-high row lines.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      sync1_q <= ROWS_IDLE;
      rs_q    <= ROWS_IDLE;
    end else begin
      sync1_q <= rows_i;
      rs_q    <= sync1_q;
    end
  end

  // Free-running column dwell counter; rows are sampled only on its last count.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) div_q <= '0;
    else if (tick_c)     div_q <= '0;
    else                 div_q <= div_q + DIV_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) state_q <= SCAN;
    else                 state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (tick_c && !idle_c) state_d = DEBOUNCE;
      DEBOUNCE: begin
        if (tick_c) begin
          if (!same_row_c)                 state_d = SCAN;
          else if (deb_inc_c == DEB_LAST)  state_d = ACCEPT;
        end
      end
      ACCEPT:   state_d = RELEASE;
      RELEASE:  if (tick_c && idle_c && (deb_inc_c == DEB_LAST)) state_d = SCAN;
      default:  state_d = SCAN;
    endcase
  end

  // FSM output and datapath next values; the strobe defaults low so it lasts one clock.
  always_comb begin
    cols_d     = cols_q;
    deb_d      = deb_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    key_d      = key_q;
    strobe_d   = 1'b0;
    held_d     = held_q;
    case (state_q)
      SCAN: begin
        if (tick_c) begin
          if (idle_c) begin
            cols_d = cols_adv_c;
          end else begin
            cand_col_d = col_index(cols_q);
            cand_row_d = cur_row_c;
            deb_d      = '0;
          end
        end
      end
      DEBOUNCE: begin
        if (tick_c) begin
          if (same_row_c) deb_d  = deb_inc_c;
          else            cols_d = cols_adv_c;
        end
      end
      ACCEPT: begin
        key_d    = code_c;
        strobe_d = 1'b1;
        held_d   = 1'b1;
        deb_d    = '0;
      end
      RELEASE: begin
        if (tick_c) begin
          if (!idle_c) begin
            deb_d = '0;
          end else if (deb_inc_c == DEB_LAST) begin
            deb_d  = '0;
            held_d = 1'b0;
            cols_d = cols_adv_c;
          end else begin
            deb_d = deb_inc_c;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      cols_q     <= COLS_RESET;
      deb_q      <= '0;
      cand_col_q <= 2'd0;
      cand_row_q <= 2'd0;
      key_q      <= 4'h0;
      strobe_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      cols_q     <= cols_d;
      deb_q      <= deb_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      key_q      <= key_d;
      strobe_q   <= strobe_d;
      held_q     <= held_d;
    end
  end

  assign cols_o        = cols_q;
  assign key_o         = key_q;
  assign enable_move_o = strobe_q;
  assign key_held_o    = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and expected-code queue.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows_i, cols_o, key_o;
  logic       en, held;

  logic       manual;
  logic [3:0] rows_man;
  logic [3:0] keys [4];
  logic [3:0] model_rows;

  logic [1:0] dcol, drow;
  logic [3:0] dcode;

  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_cnt = 0;
  bit          prev_en = 1'b0;
  bit          wide_strobe = 1'b0;
  int unsigned cyc;
  logic [3:0]  exp_q [$];

  always #10 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk_50MHz_i    (clk),
    .rst_async_la_i (rst_n),
    .rows_i         (rows_i),
    .cols_o         (cols_o),
    .key_o          (key_o),
    .enable_move_o  (en),
    .key_held_o     (held)
  );

  keypad_decoder u_dec (
    .col_i    (dcol),
    .row_i    (drow),
    .code_c_o (dcode)
  );

  // Matrix model: a row reads low when a pressed key sits in the driven column.
  always_comb begin
    model_rows = 4'hF;
    for (int r = 0; r < 4; r++) model_rows[r] = ~|(keys[r] & ~cols_o);
    rows_i = manual ? rows_man : model_rows;
  end

  // Bench clock count since reset release, used to align stimulus to dwell ticks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Strobe monitor: counts pulses and flags any strobe longer than one clock.
  always @(negedge clk) begin
    if (en) pulse_cnt++;
    if (en && prev_en) wide_strobe = 1'b1;
    prev_en = en;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (en) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_release(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (!held) begin done = 1'b1; break; end
    end
  endtask

  task automatic align_tick();
    for (int i = 0; i < 8; i++) begin
      if (cyc % 4 == 0) break;
      step(1);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols;
    manual = 1'b0; rows_man = 4'hF; clear_keys();
    rst_n = 1'b0;
    step(3);
    vectors += 4;
    if (cols_o !== 4'b1110) begin miscompares++; $display("FAIL reset_cols: got %b want 1110", cols_o); end
    if (key_o !== 4'h0) begin miscompares++; $display("FAIL reset_key: got %h want 0", key_o); end
    if (en !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b want 0", en); end
    if (held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", held); end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      vectors++;
      if (cols_o !== exp_cols) begin
        miscompares++; $display("FAIL rotate_clk%0d: got %b want %b", k, cols_o, exp_cols);
      end
    end
  endtask

  task automatic test_decoder();
    logic [3:0] tbl [16];
    tbl = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        drow = 2'(r); dcol = 2'(c);
        #1;
        vectors++;
        if (dcode !== tbl[r*4+c]) begin
          miscompares++; $display("FAIL decode_r%0d_c%0d: got %h want %h", r, c, dcode, tbl[r*4+c]);
        end
      end
    end
  endtask

  task automatic test_press_hold();
    int start; bit got; logic [3:0] exp;
    start = pulse_cnt;
    exp_q.push_back(4'h2);
    keys[0][1] = 1'b1;
    wait_pulse(60, got);
    exp = exp_q.pop_front();
    vectors += 2;
    if (!got) begin miscompares++; $display("FAIL press2_strobe: got none want pulse"); end
    if (key_o !== exp) begin miscompares++; $display("FAIL press2_key: got %h want %h", key_o, exp); end
    step(40);
    vectors += 3;
    if (pulse_cnt - start != 1) begin miscompares++; $display("FAIL press2_count: got %0d want 1", pulse_cnt - start); end
    if (key_o !== 4'h2) begin miscompares++; $display("FAIL press2_key_hold: got %h want 2", key_o); end
    if (held !== 1'b1) begin miscompares++; $display("FAIL press2_held: got %b want 1", held); end
  endtask

  task automatic test_ignore_other();
    int start; bit done;
    start = pulse_cnt;
    keys[1][2] = 1'b1;
    step(30);
    vectors += 2;
    if (pulse_cnt != start) begin miscompares++; $display("FAIL ignore_count: got %0d want 0", pulse_cnt - start); end
    if (key_o !== 4'h2) begin miscompares++; $display("FAIL ignore_key: got %h want 2", key_o); end
    clear_keys();
    wait_release(40, done);
    vectors++;
    if (!done) begin miscompares++; $display("FAIL ignore_release: held got %b want 0", held); end
  endtask

  task automatic test_back_to_back();
    int start; bit got, done; logic [3:0] exp;
    vectors++;
    if (held !== 1'b0) begin miscompares++; $display("FAIL b2b_held_before: got %b want 0", held); end
    start = pulse_cnt;
    exp_q.push_back(4'h8);
    keys[2][1] = 1'b1;
    wait_pulse(60, got);
    exp = exp_q.pop_front();
    vectors += 3;
    if (!got) begin miscompares++; $display("FAIL b2b_strobe: got none want pulse"); end
    if (key_o !== exp) begin miscompares++; $display("FAIL b2b_key: got %h want %h", key_o, exp); end
    if (held !== 1'b1) begin miscompares++; $display("FAIL b2b_held: got %b want 1", held); end
    step(20);
    vectors++;
    if (pulse_cnt - start != 1) begin miscompares++; $display("FAIL b2b_count: got %0d want 1", pulse_cnt - start); end
    clear_keys();
    wait_release(40, done);
    vectors++;
    if (!done) begin miscompares++; $display("FAIL b2b_release: held got %b want 0", held); end
  endtask

  task automatic test_bounce();
    int start; bit moved; logic [3:0] c0;
    manual = 1'b1; rows_man = 4'hF;
    align_tick();
    start = pulse_cnt;
    rows_man = 4'b1110;
    step(8);
    rows_man = 4'hF;
    step(20);
    vectors += 3;
    if (pulse_cnt != start) begin miscompares++; $display("FAIL bounce_count: got %0d want 0", pulse_cnt - start); end
    if (key_o !== 4'h8) begin miscompares++; $display("FAIL bounce_key: got %h want 8", key_o); end
    if (held !== 1'b0) begin miscompares++; $display("FAIL bounce_held: got %b want 0", held); end
    c0 = cols_o; moved = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (cols_o !== c0) begin moved = 1'b1; break; end
    end
    vectors++;
    if (!moved) begin miscompares++; $display("FAIL bounce_rescan: cols stuck at %b want rotation", cols_o); end
    manual = 1'b0;
  endtask

  task automatic test_lowest_row();
    logic [3:0] exp_tbl [3];
    bit got, done; logic [3:0] exp;
    exp_tbl = '{4'h4, 4'h6, 4'hE};
    for (int t = 0; t < 3; t++) begin
      clear_keys();
      case (t)
        0: begin keys[1][0] = 1'b1; keys[2][0] = 1'b1; end
        1: keys[1][2] = 1'b1;
        default: keys[3][0] = 1'b1;
      endcase
      exp_q.push_back(exp_tbl[t]);
      wait_pulse(60, got);
      exp = exp_q.pop_front();
      vectors += 3;
      if (!got) begin miscompares++; $display("FAIL prio%0d_strobe: got none want pulse", t); end
      if (key_o !== exp) begin miscompares++; $display("FAIL prio%0d_key: got %h want %h", t, key_o, exp); end
      if (held !== 1'b1) begin miscompares++; $display("FAIL prio%0d_held: got %b want 1", t, held); end
      step(5);
      clear_keys();
      wait_release(40, done);
      vectors++;
      if (!done) begin miscompares++; $display("FAIL prio%0d_release: held got %b want 0", t, held); end
    end
  endtask

  task automatic test_reset_debounce();
    int start;
    manual = 1'b1; rows_man = 4'hF;
    align_tick();
    rows_man = 4'b1110;
    step(6);
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (cols_o !== 4'b1110) begin miscompares++; $display("FAIL rstdeb_cols: got %b want 1110", cols_o); end
    if (key_o !== 4'h0) begin miscompares++; $display("FAIL rstdeb_key: got %h want 0", key_o); end
    if (en !== 1'b0) begin miscompares++; $display("FAIL rstdeb_strobe: got %b want 0", en); end
    if (held !== 1'b0) begin miscompares++; $display("FAIL rstdeb_held: got %b want 0", held); end
    step(2);
    rows_man = 4'hF;
    rst_n = 1'b1;
    start = pulse_cnt;
    step(30);
    vectors++;
    if (pulse_cnt != start) begin miscompares++; $display("FAIL rstdeb_count: got %0d want 0", pulse_cnt - start); end
    manual = 1'b0;
  endtask

  task automatic test_reset_release();
    int start; bit got, done; logic [3:0] exp;
    clear_keys();
    keys[0][0] = 1'b1;
    exp_q.push_back(4'h1);
    wait_pulse(60, got);
    exp = exp_q.pop_front();
    vectors += 2;
    if (!got) begin miscompares++; $display("FAIL rstrel_strobe: got none want pulse"); end
    if (key_o !== exp) begin miscompares++; $display("FAIL rstrel_key: got %h want %h", key_o, exp); end
    step(5);
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (key_o !== 4'h0) begin miscompares++; $display("FAIL rstrel_rkey: got %h want 0", key_o); end
    if (held !== 1'b0) begin miscompares++; $display("FAIL rstrel_rheld: got %b want 0", held); end
    if (cols_o !== 4'b1110) begin miscompares++; $display("FAIL rstrel_rcols: got %b want 1110", cols_o); end
    step(2);
    rst_n = 1'b1;
    start = pulse_cnt;
    step(8);
    vectors++;
    if (pulse_cnt != start) begin miscompares++; $display("FAIL rstrel_early: got %0d want 0", pulse_cnt - start); end
    exp_q.push_back(4'h1);
    wait_pulse(60, got);
    exp = exp_q.pop_front();
    vectors += 3;
    if (!got) begin miscompares++; $display("FAIL rstrel_repress: got none want pulse"); end
    if (key_o !== exp) begin miscompares++; $display("FAIL rstrel_rekey: got %h want %h", key_o, exp); end
    if (held !== 1'b1) begin miscompares++; $display("FAIL rstrel_reheld: got %b want 1", held); end
    clear_keys();
    wait_release(40, done);
    vectors++;
    if (!done) begin miscompares++; $display("FAIL rstrel_release: held got %b want 0", held); end
  endtask

  initial begin
    manual = 1'b0; rows_man = 4'hF; rst_n = 1'b0;
    dcol = 2'd0; drow = 2'd0;
    clear_keys();
    test_reset();
    test_decoder();
    test_press_hold();
    test_ignore_other();
    test_back_to_back();
    test_bounce();
    test_lowest_row();
    test_reset_debounce();
    test_reset_release();
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
    if (wide_strobe) begin miscompares++; $display("FAIL strobe_width: got >1 clock want 1 clock"); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
